// File: rtl/spi_prog_sequencer_if.sv
// Request and SPI byte-engine signals shared by the loader, the sequencer and spi_master.
// The master side drives requests and spi_done; the slave side is the sequencer.
interface spi_prog_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        spi_start;
    logic [7:0]  spi_data;
    logic        spi_done;

    modport master (
        output req_valid, req_addr, req_data, spi_done,
        input  req_ready, spi_start, spi_data
    );

    modport slave (
        input  req_valid, req_addr, req_data, spi_done,
        output req_ready, spi_start, spi_data
    );
endinterface

// File: rtl/spi_prog_sequencer.sv
// Turns 32-bit word writes into the address/data command byte frame of the SPI
// programming slave, pacing an spi_master byte engine with gaps and a per-byte timeout.
module spi_prog_sequencer #(
    parameter logic [7:0]  ADDR_CMD       = 8'h01,
    parameter logic [7:0]  DATA_CMD       = 8'h02,
    parameter logic [31:0] ADDR_STRIDE    = 32'd4,
    parameter bit          SKIP_SEQ_ADDR  = 1'b0,
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input  logic                       clk,
    input  logic                       rst_n,
    spi_prog_sequencer_if.slave        bus,
    output logic                       busy,
    output logic                       err,
    input  logic                       err_clr,
    output logic [15:0]                words_written
);

    localparam int unsigned      GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam int unsigned      TO_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit               TO_EN     = (TIMEOUT_CYCLES != 0);
    localparam logic [3:0]       LAST_IDX  = 4'd9;
    localparam logic [3:0]       DATA_IDX  = 4'd5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GAP   = 2'd1,
        S_START = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t            r_state;
    logic [3:0]        r_idx;
    logic [31:0]       r_addr;
    logic [31:0]       r_data;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_done_q;
    logic [31:0]       r_pred_addr;
    logic              r_pred_vld;
    logic              r_spi_start;
    logic [7:0]        r_spi_data;
    logic              r_ready;
    logic              r_busy;
    logic              r_err;
    logic [15:0]       r_words;

    logic              w_done_rise;
    logic              w_skip;
    logic              w_timeout;

    // Byte at position idx of a full frame; the short frame simply starts at DATA_IDX.
    function automatic logic [7:0] frame_byte(input logic [3:0] idx,
                                              input logic [31:0] a,
                                              input logic [31:0] d);
        logic [7:0] b;
        case (idx)
            4'd0:    b = ADDR_CMD;
            4'd1:    b = a[31:24];
            4'd2:    b = a[23:16];
            4'd3:    b = a[15:8];
            4'd4:    b = a[7:0];
            4'd5:    b = DATA_CMD;
            4'd6:    b = d[31:24];
            4'd7:    b = d[23:16];
            4'd8:    b = d[15:8];
            4'd9:    b = d[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign w_done_rise = bus.spi_done & ~r_done_q;
    assign w_skip      = SKIP_SEQ_ADDR && r_pred_vld && (bus.req_addr == r_pred_addr);
    assign w_timeout   = (r_state == S_WAIT) && !w_done_rise && TO_EN && (r_to_cnt == TO_LAST);

    // Sequencer FSM with all outputs, prediction, timeout and status held in registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= 4'd0;
            r_addr      <= 32'd0;
            r_data      <= 32'd0;
            r_gap_cnt   <= '0;
            r_to_cnt    <= '0;
            r_done_q    <= 1'b0;
            r_pred_addr <= 32'd0;
            r_pred_vld  <= 1'b0;
            r_spi_start <= 1'b0;
            r_spi_data  <= 8'h00;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_words     <= 16'd0;
        end else begin
            r_done_q <= bus.spi_done;

            // Timeout wins over a simultaneous clear so an abort is never lost.
            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end else begin
                r_err <= r_err;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_addr    <= bus.req_addr;
                        r_data    <= bus.req_data;
                        r_idx     <= w_skip ? DATA_IDX : 4'd0;
                        r_gap_cnt <= '0;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= S_GAP;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_spi_start <= 1'b1;
                        r_spi_data  <= frame_byte(r_idx, r_addr, r_data);
                        r_state     <= S_START;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    end
                end
                S_START: begin
                    r_spi_start <= 1'b0;
                    r_to_cnt    <= '0;
                    r_state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_done_rise) begin
                        if (r_idx == LAST_IDX) begin
                            r_words     <= r_words + 16'd1;
                            r_pred_addr <= r_addr + ADDR_STRIDE;
                            r_pred_vld  <= 1'b1;
                            r_ready     <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= S_IDLE;
                        end else begin
                            r_idx     <= r_idx + 4'd1;
                            r_gap_cnt <= '0;
                            r_state   <= S_GAP;
                        end
                    end else if (w_timeout) begin
                        r_pred_vld <= 1'b0;
                        r_ready    <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                default: begin
                    r_spi_start <= 1'b0;
                    r_ready     <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_ready;
    assign bus.spi_start  = r_spi_start;
    assign bus.spi_data   = r_spi_data;
    assign busy           = r_busy;
    assign err            = r_err;
    assign words_written  = r_words;

endmodule

// File: tb/tb_spi_prog_sequencer.sv
// Directed bench for spi_prog_sequencer: a frame model predicts the byte stream,
// a per-cycle monitor compares every start pulse against it.
module tb_spi_prog_sequencer;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        err_clr = 1'b0;
    logic        busy;
    logic        err;
    logic [15:0] words_written;

    spi_prog_sequencer_if bus();

    spi_prog_sequencer #(
        .SKIP_SEQ_ADDR (1'b1),
        .GAP_CYCLES    (2),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .busy         (busy),
        .err          (err),
        .err_clr      (err_clr),
        .words_written(words_written)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          n_starts = 0;
    logic        prev_start = 1'b0;
    logic [7:0]  exp_q[$];
    logic        m_pv = 1'b0;
    logic [31:0] m_pa = 32'd0;
    logic [15:0] m_words = 16'd0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, want, $time);
        end
    endfunction

    // Expected frame: full unless the address equals the model's live prediction.
    function automatic int push_frame(input logic [31:0] a, input logic [31:0] d);
        int cnt = 0;
        if (!(m_pv && a == m_pa)) begin
            exp_q.push_back(8'h01);
            for (int i = 3; i >= 0; i--) exp_q.push_back(8'((a >> (8 * i)) & 32'hFF));
            cnt = 5;
        end
        exp_q.push_back(8'h02);
        for (int i = 3; i >= 0; i--) exp_q.push_back(8'((d >> (8 * i)) & 32'hFF));
        return cnt + 5;
    endfunction

    // Monitor: every start pulse must carry the next predicted byte.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("ready_vs_busy", 32'(bus.req_ready), 32'(!busy));
            if (bus.spi_start) begin
                chk("start_one_cycle", 32'(prev_start), 32'd0);
                n_starts++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_start: byte 0x%0h, none expected at %0t", bus.spi_data, $time);
                end else begin
                    chk("spi_byte", 32'(bus.spi_data), 32'(exp_q.pop_front()));
                end
            end
            prev_start = bus.spi_start;
        end else begin
            prev_start = 1'b0;
        end
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_start"}, 32'(bus.spi_start), 32'd0);
        chk({tag, "_data"},  32'(bus.spi_data), 32'd0);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_err"},   32'(err), 32'd0);
        chk({tag, "_words"}, 32'(words_written), 32'd0);
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    endtask

    task automatic send_word(input logic [31:0] a, input logic [31:0] d, input int lat,
                             input int exp_n, input int hang_at, input int hold_at,
                             input int rst_at, input logic clr_at_to);
        int n;
        int start0;
        int waited;
        n = push_frame(a, d);
        chk("frame_len", 32'(n), 32'(exp_n));
        start0 = n_starts;
        waited = 0;
        @(negedge clk);
        while (!bus.req_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk("ready_before_req", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_data  = d;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("ready_low_after_accept", 32'(bus.req_ready), 32'd0);
        for (int b = 0; b < n; b++) begin
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (!bus.spi_start && waited < 60);
            chk("start_seen", 32'(bus.spi_start), 32'd1);
            if (!bus.spi_start) begin
                exp_q.delete();
                return;
            end
            if (b == rst_at) begin
                rst_n = 1'b0;
                @(posedge clk);
                @(negedge clk);
                check_reset_values("mid_reset");
                rst_n = 1'b1;
                exp_q.delete();
                m_words = 16'd0;
                m_pv = 1'b0;
                return;
            end
            if (b == hang_at) begin
                repeat (TO) @(posedge clk);
                #1 err_clr = clr_at_to;
                @(negedge clk);
                chk("busy_before_abort", 32'(busy), 32'd1);
                @(posedge clk);
                #1 err_clr = 1'b0;
                @(negedge clk);
                m_pv = 1'b0;
                exp_q.delete();
                chk("busy_after_abort", 32'(busy), 32'd0);
                chk("err_after_abort", 32'(err), 32'd1);
                chk("ready_after_abort", 32'(bus.req_ready), 32'd1);
                chk("words_after_abort", 32'(words_written), 32'(m_words));
                chk("starts_before_abort", 32'(n_starts - start0), 32'(b + 1));
                return;
            end
            if (b == hold_at) begin
                bus.spi_done = 1'b1;
                repeat (5) @(posedge clk);
                #1 bus.spi_done = 1'b0;
                chk("hold_still_busy", 32'(busy), 32'd1);
                chk("hold_no_advance", 32'(n_starts - start0), 32'(b + 1));
                repeat (2) @(posedge clk);
                #1 bus.spi_done = 1'b1;
            end else begin
                repeat (lat) @(posedge clk);
                #1 bus.spi_done = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            chk("busy_after_done", 32'(busy), 32'(b != n - 1));
            @(posedge clk);
            #1 bus.spi_done = 1'b0;
        end
        m_words = m_words + 16'd1;
        m_pv = 1'b1;
        m_pa = a + 32'd4;
        chk("start_count", 32'(n_starts - start0), 32'(exp_n));
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("words", 32'(words_written), 32'(m_words));
        chk("ready_after_word", 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] lit[10];
        int         n;
        lit = '{8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'd0;
        bus.req_data  = 32'd0;
        bus.spi_done  = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // Pin the frame model against a hand-written byte list.
        n = push_frame(32'h1000_0000, 32'hDEAD_BEEF);
        chk("model_len", 32'(n), 32'd10);
        for (int i = 0; i < 10; i++) chk("model_byte", 32'(exp_q[i]), 32'(lit[i]));
        exp_q.delete();

        send_word(32'h1000_0000, 32'hDEAD_BEEF, 6, 10, -1, -1, -1, 1'b0);
        chk("words_lit1", 32'(words_written), 32'd1);
        send_word(32'h1000_0004, 32'h1122_3344, 6, 5, -1, -1, -1, 1'b0);
        send_word(32'h1000_0010, 32'h5566_7788, 3, 10, -1, -1, -1, 1'b0);
        chk("words_lit3", 32'(words_written), 32'd3);
        // Longest latency that still completes: done rises in the last timeout cycle.
        send_word(32'h1000_0014, 32'hA5A5_5A5A, TO, 5, -1, -1, -1, 1'b0);
        chk("err_lit0", 32'(err), 32'd0);

        send_word(32'h2000_0000, 32'hCAFE_F00D, 6, 10, 3, -1, -1, 1'b0);
        chk("words_lit4", 32'(words_written), 32'd4);
        // Prediction was dropped by the abort, so this sequential address gets a full frame.
        send_word(32'h1000_0018, 32'h0BAD_F00D, 6, 10, -1, 2, -1, 1'b0);

        chk("err_before_clr", 32'(err), 32'd1);
        @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        @(negedge clk);
        chk("err_clr_alone", 32'(err), 32'd0);

        send_word(32'h3000_0000, 32'h1234_5678, 6, 10, 0, -1, -1, 1'b1);
        send_word(32'h5000_0000, 32'h0F0F_0F0F, 6, 10, -1, -1, -1, 1'b0);
        chk("words_lit6", 32'(words_written), 32'd6);
        send_word(32'h6000_0000, 32'h1212_1212, 6, 10, -1, -1, 6, 1'b0);
        send_word(32'h5000_0004, 32'h89AB_CDEF, 6, 10, -1, -1, -1, 1'b0);
        chk("words_after_reset", 32'(words_written), 32'd1);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_prog_sequencer.md
Name: spi_prog_sequencer

Overview:
- Controller that turns 32-bit word-write requests into the byte sequence the chip's SPI programming slave expects, and drives an spi_master byte engine (start/done/data_in).
- Frame per word: address command 0x01, four address bytes MSB-first, data command 0x02, four data bytes MSB-first.
- Sits between a loader (BIOS image streamer or host bridge) and spi_master. Replaces hand-sequenced bench stimulus.
- Provides optional address-phase elision for sequential words, a per-byte timeout, and progress status.

Parameters:
- ADDR_CMD, 8'h01, command byte that opens the address phase
- DATA_CMD, 8'h02, command byte that opens the data phase
- ADDR_STRIDE, 4, expected address increment between consecutive words
- SKIP_SEQ_ADDR, 0, when 1, omit the address phase if req_addr equals the predicted next address
- GAP_CYCLES, 2, idle cycles inserted before each spi_start pulse
- TIMEOUT_CYCLES, 65536, max cycles waiting for spi_done per byte; 0 disables the timeout

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  word-write request valid
- req_ready  out  1  sequencer can accept a request
- req_addr  in  32  target address
- req_data  in  32  word to write
- spi_start  out  1  one-cycle pulse launching a byte on spi_master
- spi_data  out  8  byte to send; stable from the start pulse until done
- spi_done  in  1  spi_master done; its rising edge marks byte completion
- busy  out  1  high from request accept until the last byte completes or aborts
- err  out  1  sticky timeout flag
- err_clr  in  1  clears err
- words_written  out  16  count of fully written words; wraps at 0xFFFF

Behaviour:
- Reset (rst_n=0 sampled at posedge):
  - state IDLE; spi_start=0, spi_data=0, busy=0, err=0, words_written=0.
  - Predicted-address valid flag cleared; done edge register cleared.
  - req_ready = (state==IDLE); it reads 1 after reset.
- Handshake:
  - Accept when req_valid && req_ready at a posedge; latch addr and data.
  - busy rises the next cycle. req_ready stays low until the sequence ends.
  - A request arriving while not ready is held by the requester and is not dropped.
- Byte list:
  - Full frame (10 bytes): ADDR_CMD, A[31:24], A[23:16], A[15:8], A[7:0], DATA_CMD, D[31:24], D[23:16], D[15:8], D[7:0].
  - Short frame (5 bytes, DATA_CMD onward): used only when SKIP_SEQ_ADDR=1, the prediction flag is valid, and req_addr == pred_addr.
- FSM states:
  - IDLE -> GAP on accept.
  - GAP: counts GAP_CYCLES cycles (0 means pass through in one cycle), then -> START.
  - START: spi_start=1 for exactly one cycle, spi_data=current byte -> WAIT.
  - WAIT: on detected rising edge of spi_done (done & ~done_q):
    - byte index increments; if more bytes remain -> GAP;
    - else -> IDLE, words_written+1, pred_addr=addr+ADDR_STRIDE (32-bit wrap), prediction flag set.
  - Minimum per-byte overhead: GAP_CYCLES+2 cycles plus the SPI transfer time.
- Edge rules:
  - spi_done high on entry to WAIT, without a new rising edge, does not count as completion.
  - A rising edge seen outside WAIT is ignored.
- Timeout (TIMEOUT_CYCLES>0):
  - Counter clears on entering WAIT. When it reaches TIMEOUT_CYCLES-1 with no edge, abort:
    - -> IDLE, err=1, prediction flag cleared, words_written unchanged;
    - the next request always sends a full frame.
- err: set-dominant. A timeout and err_clr in the same cycle leave err=1.
- spi_data holds its last value in IDLE. Only spi_start qualifies the byte.
- Reset mid-sequence: immediate return to reset values. No partial-frame recovery. spi_start never pulses in the reset cycle.

Test Plan:
- Single write: addr 0x1000_0000, data 0xDEAD_BEEF, done model 20 cycles after start -> 10 start pulses with bytes 01 10 00 00 00 02 DE AD BE EF; words_written=1; busy falls with the last done edge.
- Back-to-back, SKIP_SEQ_ADDR=1: 0x1000_0000 then 0x1000_0004 then 0x1000_0010 -> bytes 10, 5, 10; words_written=3.
- Timeout, TIMEOUT_CYCLES=16: spi_done never rises on byte 3 -> abort exactly 16 cycles after entering WAIT; err=1; req_ready=1; next request to predicted address sends a full 10-byte frame.
- Done level held high across WAIT entry, then low, then a rising edge -> only the rising edge advances the index; no byte skipped.
- rst_n low during byte 6 -> next cycle all outputs at reset values, words_written=0; a new request sends a full frame.
- err_clr asserted alone -> err=0. err_clr together with a timeout -> err remains 1. 65536 writes -> words_written wraps to 0.
